i8080_pixel_rx: RTL and testbench

//  Upstream of the RGB LCD timing/FIFO-read stage. Oversamples an 8-bit i8080 MCU write bus in
//  the PixelClk domain and decodes memory-write commands. Packs byte pairs into RGB565 words and

---
 rtl/i8080_pixel_rx.sv | 174 +++++++++++++++++
 tb/tb_i8080_pixel_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i8080_pixel_rx.sv
// i8080_pixel_rx
//   Oversamples an 8-bit i8080 MCU write bus in the PixelClk domain and decodes
//   memory-write commands. Byte pairs are packed into RGB565 words and pushed
//   into the pixel FIFO. A start-of-frame pulse is issued for the timing stage.
//
// Ports
//   PixelClk     in   1   sole clock
//   nRST         in   1   asynchronous, active-low reset
//   I80_CS_N     in   1   chip select (async)
//   I80_WR_N     in   1   write strobe (async), bus latched on its rising edge
//   I80_RS       in   1   0 = command byte, 1 = data byte (async)
//   I80_DB       in   8   data bus (async)
//   FIFO_Full    in   1   pixel FIFO full
//   FIFO_WE      out  1   FIFO write enable, one cycle per pixel
//   FIFO_WDATA   out  16  RGB565 pixel {first byte, second byte}
//   FrameCtrl    out  1   one-cycle pulse on accepted start-memory-write
//   FrameDone    out  1   one-cycle pulse when PixelCnt reaches FRAME_PIXELS
//   Busy         out  1   high while a memory write is active
//   Overflow     out  1   sticky: a pixel was dropped because FIFO_Full
//   PixelCnt     out  20  pixels accepted since the last start-memory-write
//   dbg_state_o  out  2   current FSM state (IDLE=0, PIX_HI=1, PIX_LO=2)
//
// Handshake: the write side has no back-pressure. FIFO_WE is a one-cycle
// valid; FIFO_Full acts as a not-ready sampled in the push cycle, and a pixel
// offered while it is high is dropped (Overflow set) rather than stalled.
module i8080_pixel_rx #(
  parameter int          SYNC_STAGES  = 2,
  parameter int          FRAME_PIXELS = 384000,
  parameter logic [7:0]  CMD_MEMWR    = 8'h2C,
  parameter logic [7:0]  CMD_MEMWRC   = 8'h3C
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        I80_CS_N,
  input  logic        I80_WR_N,
  input  logic        I80_RS,
  input  logic [7:0]  I80_DB,
  input  logic        FIFO_Full,
  output logic        FIFO_WE,
  output logic [15:0] FIFO_WDATA,
  output logic        FrameCtrl,
  output logic        FrameDone,
  output logic        Busy,
  output logic        Overflow,
  output logic [19:0] PixelCnt,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0]  IDLE   = 2'd0;
  localparam logic [1:0]  PIX_HI = 2'd1;
  localparam logic [1:0]  PIX_LO = 2'd2;

  localparam int          LAST      = SYNC_STAGES - 1;
  localparam logic [19:0] FRAME_CNT = 20'(FRAME_PIXELS);
  // Synchroniser reset value: CS_N=1, WR_N=1, RS=0, DB=0.
  localparam logic [10:0] SYNC_RST  = 11'b110_0000_0000;

  // All bus bits travel through the same chain so byte/RS/strobe are coherent.
  logic [10:0] sync_q [SYNC_STAGES];
  logic        wr_prev_q;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      wr_prev_q <= 1'b1;
    end else begin
      sync_q[0] <= {I80_CS_N, I80_WR_N, I80_RS, I80_DB};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wr_prev_q <= sync_q[LAST][9];
    end
  end

  logic       cs_n_s, wr_n_s, rs_s, strobe;
  logic [7:0] db_s;

  assign cs_n_s = sync_q[LAST][10];
  assign wr_n_s = sync_q[LAST][9];
  assign rs_s   = sync_q[LAST][8];
  assign db_s   = sync_q[LAST][7:0];
  assign strobe = !wr_prev_q && wr_n_s && !cs_n_s;

  logic [1:0]  state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [19:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic        fc_q, fc_d;
  logic        fd_q, fd_d;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    fc_d    = 1'b0;
    fd_d    = 1'b0;

    if (strobe && !rs_s) begin
      if (db_s == CMD_MEMWR) begin
        state_d = PIX_HI;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        fc_d    = 1'b1;
      end else if (db_s == CMD_MEMWRC) begin
        state_d = PIX_HI;
      end else begin
        state_d = IDLE;
      end
    end else if (strobe && rs_s) begin
      case (state_q)
        PIX_HI: begin
          hi_d    = db_s;
          state_d = PIX_LO;
        end
        PIX_LO: begin
          if (FIFO_Full) begin
            ovf_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            wdata_d = {hi_q, db_s};
          end
          state_d = PIX_HI;
          // A continued write past a finished frame saturates the count.
          if (cnt_q != FRAME_CNT) begin
            cnt_d = cnt_q + 20'd1;
            if (cnt_q + 20'd1 == FRAME_CNT) begin
              fd_d    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: ;
      endcase
    end else if (cs_n_s && state_q == PIX_LO) begin
      // Deselect mid-pixel: drop the half pixel, keep the memory write open.
      state_d = PIX_HI;
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      hi_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      fc_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      fc_q    <= fc_d;
      fd_q    <= fd_d;
    end
  end

  assign FIFO_WE     = we_q;
  assign FIFO_WDATA  = wdata_q;
  assign FrameCtrl   = fc_q;
  assign FrameDone   = fd_q;
  assign Busy        = (state_q == PIX_HI) || (state_q == PIX_LO);
  assign Overflow    = ovf_q;
  assign PixelCnt    = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i8080_pixel_rx.sv
// Testbench for i8080_pixel_rx with FRAME_PIXELS overridden to 4.
// The bench keeps a transaction-level model of the byte stream (frame open,
// pending high byte, pixel count, overflow) and queues the pixels it expects.
// A monitor checks every FIFO push against the queue; steady-state outputs are
// checked after each bus transaction.
module tb_i8080_pixel_rx;

  localparam int FRAME = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cs_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        rs = 1'b0;
  logic [7:0]  db = 8'h00;
  logic        fifo_full = 1'b0;
  logic        fifo_we;
  logic [15:0] fifo_wdata;
  logic        frame_ctrl, frame_done, busy, overflow;
  logic [19:0] pixel_cnt;
  logic [1:0]  dbg_state;

  i8080_pixel_rx #(.FRAME_PIXELS(FRAME)) dut (
    .PixelClk   (clk),
    .nRST       (nrst),
    .I80_CS_N   (cs_n),
    .I80_WR_N   (wr_n),
    .I80_RS     (rs),
    .I80_DB     (db),
    .FIFO_Full  (fifo_full),
    .FIFO_WE    (fifo_we),
    .FIFO_WDATA (fifo_wdata),
    .FrameCtrl  (frame_ctrl),
    .FrameDone  (frame_done),
    .Busy       (busy),
    .Overflow   (overflow),
    .PixelCnt   (pixel_cnt),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  bit          m_active = 0;   // memory write open
  bit          m_have_hi = 0;  // first byte of a pixel held
  logic [7:0]  m_hi = 8'h00;
  int          m_cnt = 0;
  bit          m_ovf = 0;
  int          m_fc = 0;       // expected FrameCtrl pulses
  int          m_fd = 0;       // expected FrameDone pulses

  int          seen_fc = 0;
  int          seen_fd = 0;
  int          seen_we = 0;
  logic [15:0] last_wdata = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_byte(input bit is_data, input logic [7:0] b);
    if (!is_data) begin
      m_have_hi = 0;
      if (b == 8'h2C) begin
        m_active = 1; m_cnt = 0; m_ovf = 0; m_fc++;
      end else if (b == 8'h3C) begin
        m_active = 1;
      end else begin
        m_active = 0;
      end
    end else if (m_active) begin
      if (!m_have_hi) begin
        m_hi = b; m_have_hi = 1;
      end else begin
        m_have_hi = 0;
        if (fifo_full) m_ovf = 1;
        else exp_q.push_back({m_hi, b});
        m_cnt++;
        if (m_cnt == FRAME) begin
          m_fd++; m_active = 0;
        end
      end
    end
  endfunction

  // Monitor: every cycle, any push must match the head of the expected queue.
  always @(negedge clk) begin
    if (nrst) begin
      if (frame_ctrl) seen_fc++;
      if (frame_done) seen_fd++;
      if (fifo_we) begin
        seen_we++;
        last_wdata = fifo_wdata;
        if (exp_q.size() == 0) chk("unexpected_push", {16'h0, fifo_wdata}, 32'hFFFF_FFFF);
        else chk("push_data", {16'h0, fifo_wdata}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_byte(input bit is_data, input logic [7:0] b);
    @(negedge clk);
    cs_n = 1'b0; rs = is_data; db = b; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    model_byte(is_data, b);
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_toggle();
    @(negedge clk);
    cs_n = 1'b1;
    if (m_active) m_have_hi = 0;
    repeat (5) @(negedge clk);
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_busy"},      {31'h0, busy},      {31'h0, m_active});
    chk({tag, "_pixelcnt"},  {12'h0, pixel_cnt}, m_cnt);
    chk({tag, "_overflow"},  {31'h0, overflow},  {31'h0, m_ovf});
    chk({tag, "_pending"},   exp_q.size(),       0);
    chk({tag, "_framectrl"}, seen_fc,            m_fc);
    chk({tag, "_framedone"}, seen_fd,            m_fd);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_zero_outs"},
        {16'h0, fifo_we, frame_ctrl, frame_done, busy, overflow, 11'h0},
        32'h0);
    chk({tag, "_zero_cnt"},   {12'h0, pixel_cnt},  32'h0);
    chk({tag, "_zero_wdata"}, {16'h0, fifo_wdata}, 32'h0);
  endtask

  task automatic data_bytes(input logic [7:0] b[$]);
    foreach (b[i]) write_byte(1'b1, b[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int we_before;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check_state("idle");

    // 1: basic frame start and two pixels
    write_byte(1'b0, 8'h2C);
    data_bytes('{8'hF8, 8'h00, 8'h07, 8'hE0});
    check_state("t1");
    chk("t1_cnt_literal", {12'h0, pixel_cnt}, 32'd2);
    chk("t1_last_literal", {16'h0, last_wdata}, 32'h07E0);
    chk("t1_fc_literal", seen_fc, 1);

    // 2: full frame of FRAME pixels, trailing bytes ignored
    we_before = seen_we;
    write_byte(1'b0, 8'h2C);
    data_bytes('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A});
    check_state("t2");
    chk("t2_push_literal", seen_we - we_before, 4);
    chk("t2_done_literal", seen_fd, 1);
    chk("t2_busy_literal", {31'h0, busy}, 32'h0);
    chk("t2_last_literal", {16'h0, last_wdata}, 32'h0708);

    // 3: FIFO full during the second pixel
    we_before = seen_we;
    write_byte(1'b0, 8'h2C);
    data_bytes('{8'h11, 8'h22});
    fifo_full = 1'b1;
    data_bytes('{8'h33, 8'h44});
    fifo_full = 1'b0;
    check_state("t3");
    chk("t3_push_literal", seen_we - we_before, 1);
    chk("t3_ovf_literal", {31'h0, overflow}, 32'h1);
    write_byte(1'b0, 8'h2C);
    check_state("t3_clear");

    // 4: foreign command aborts half pixel; continue-write keeps count
    data_bytes('{8'hAA});
    write_byte(1'b0, 8'h2A);
    check_state("t4_abort");
    write_byte(1'b0, 8'h3C);
    data_bytes('{8'h12, 8'h34});
    check_state("t4");
    chk("t4_last_literal", {16'h0, last_wdata}, 32'h1234);

    // 5: chip-select bounce discards the held half pixel
    data_bytes('{8'hAA});
    cs_toggle();
    data_bytes('{8'h55, 8'h66});
    check_state("t5");
    chk("t5_last_literal", {16'h0, last_wdata}, 32'h5566);

    // 6: reset mid-frame
    write_byte(1'b0, 8'h2C);
    data_bytes('{8'hDE, 8'hAD, 8'hBE});
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check_all_zero("t6_rst");
    m_active = 0; m_have_hi = 0; m_cnt = 0; m_ovf = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    we_before = seen_we;
    data_bytes('{8'hEF, 8'h77});
    check_state("t6");
    chk("t6_nopush_literal", seen_we - we_before, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
